tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Receive end of the 4:1 mux path: takes a time-division-multiplexed sample stream, one sample per slot, four slots per frame.
- Distributes each sample to channel outputs a/b/c/d; slot order matches the mux select encoding {s1,s0}: 00->a, 01->b, 10->c, 11->d.
- A frame_sync marker establishes alignment.
- Outputs update atomically once per completed frame, so downstream logic never sees a mixed frame.

Parameters:
- WIDTH, 1, bit width of each sample and of each channel output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  incoming multiplexed sample.
- din_valid  in  1  din carries a sample this cycle; a sample is accepted on any rising edge with din_valid=1 (no backpressure).
- frame_sync  in  1  qualifies the accepted sample as slot 0; ignored when din_valid=0.
- a, b, c, d  out  WIDTH  registered channel outputs (slots 0..3).
- frame_valid  out  1  one-cycle pulse: a..d were just updated with a complete frame.
- slot  out  2  index of the slot expected next (00..11).
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - a=b=c=d=0, frame_valid=0, sync_err=0, slot=00, locked=0.
  - State HUNT; shadow registers cleared.
  - Reset mid-frame discards any partial frame.
- States: HUNT, LOCKED.
- HUNT:
  - Samples with frame_sync=0 are dropped; slot stays 00; no error.
  - Sample with frame_sync=1: stored to shadow[0]; slot<=01; go LOCKED.
- LOCKED, accepted sample, slot=01 or 10:
  - frame_sync=0: stored to shadow[slot]; slot increments.
  - frame_sync=1 (early sync): sync_err pulses; partial frame discarded; this sample stored to shadow[0]; slot<=01; stay LOCKED.
- LOCKED, accepted sample, slot=11:
  - frame_sync=0: on the same edge a<=shadow[0], b<=shadow[1], c<=shadow[2], d<=din; frame_valid=1 for the following cycle; slot wraps to 00.
  - frame_sync=1: treated as early sync, same as above; a..d unchanged.
- LOCKED, accepted sample, slot=00:
  - frame_sync=1: starts the next frame (shadow[0], slot<=01).
  - frame_sync=0 (missing sync): sync_err pulses; sample dropped; go HUNT; a..d retain the last complete frame.
- Cycles with din_valid=0: no state change; gaps between samples of any length are legal.
- Latency: a..d reflect the frame on the rising edge that accepts its slot-3 sample. frame_valid and the new a..d are visible together in the cycle after that edge.
- frame_valid and sync_err are never high in the same cycle. Each is a single-cycle pulse; back-to-back frames give one pulse per frame.
- a..d hold their value between frames. Only a complete four-slot frame modifies them.

Decomposition:
- Shared package tdm_pkg:
  - state enum (HUNT, LOCKED).
  - slot constants SLOT_A=2'b00, SLOT_B=2'b01, SLOT_C=2'b10, SLOT_D=2'b11, shared with the mux select encoding.
- No sub-module required. The slot counter and shadow registers fit in one module, about 150 lines.

Test Plan:
- Reset then frame: rst_n low 3 cycles, release; send din=1,0,0,1 with frame_sync on the first sample -> a=1,b=0,c=0,d=1; one frame_valid pulse; slot=00; locked=1.
- Back-to-back frames with gaps: frames (0,1,1,1) then (1,0,1,1), din_valid=0 for 2 cycles between samples -> two frame_valid pulses; final a=1,b=0,c=1,d=1.
- Hunt: 3 samples without frame_sync, then a valid frame (1,1,1,0) -> first 3 samples ignored; locked rises on the sync sample; a..d=1,1,1,0.
- Early sync: frame_sync on slot 2 of a frame -> sync_err pulse; a..d unchanged; the following three samples 0,0,1 complete a frame -> (x_sync,0,0,1) appears with frame_valid.
- Missing sync at slot 0 -> sync_err pulse; locked=0; a..d hold the prior frame; recovery on the next sync.
- Reset mid-frame after 2 samples -> outputs 0, slot=00, HUNT; no frame_valid pulse emitted.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg
// Shared definitions for the TDM mux/demux path.
//   state_t        : receiver alignment state (HUNT, LOCKED)
//   SLOT_A..SLOT_D : slot indices, identical to the 4:1 mux select
//                    encoding {s1,s0}, so slot n feeds channel a/b/c/d.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

endpackage

// File: rtl/tdm_demux4.sv
// tdm_demux4
// Receive end of the 4:1 TDM path. Accepts one sample per valid cycle,
// aligns to frame_sync (marks slot 0), collects slots 0..2 in shadow
// registers and publishes a complete frame to a..d atomically on the edge
// that accepts the slot-3 sample.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   din, din_valid        : multiplexed sample and its qualifier
//   frame_sync            : marks the accepted sample as slot 0
//   a, b, c, d            : registered channel outputs (slots 0..3)
//   frame_valid           : one-cycle pulse, a..d just got a new frame
//   slot                  : index of the slot expected next
//   locked                : high while aligned (LOCKED)
//   sync_err              : one-cycle pulse on an alignment violation
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  state_t           state;
  logic [WIDTH-1:0] shadow_0;
  logic [WIDTH-1:0] shadow_1;
  logic [WIDTH-1:0] shadow_2;

  // Alignment FSM, slot counter, shadow capture and output publish.
  // The slot-3 sample goes straight to d so the frame lands in a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= SLOT_A;
      locked      <= 1'b0;
      shadow_0    <= '0;
      shadow_1    <= '0;
      shadow_2    <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow_0 <= din;
              slot     <= SLOT_B;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (slot == SLOT_A) begin
              if (frame_sync) begin
                shadow_0 <= din;
                slot     <= SLOT_B;
              end else begin
                // Missing sync: drop sample and realign; a..d keep last frame.
                sync_err <= 1'b1;
                state    <= HUNT;
                locked   <= 1'b0;
              end
            end else if (frame_sync) begin
              // Early sync restarts the frame; stale shadows get overwritten.
              sync_err <= 1'b1;
              shadow_0 <= din;
              slot     <= SLOT_B;
            end else begin
              case (slot)
                SLOT_B: begin
                  shadow_1 <= din;
                  slot     <= SLOT_C;
                end
                SLOT_C: begin
                  shadow_2 <= din;
                  slot     <= SLOT_D;
                end
                default: begin
                  a           <= shadow_0;
                  b           <= shadow_1;
                  c           <= shadow_2;
                  d           <= din;
                  frame_valid <= 1'b1;
                  slot        <= SLOT_A;
                end
              endcase
            end
          end
          default: begin
            state  <= HUNT;
            slot   <= SLOT_A;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
